// File: rtl/harmonic_phase_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// harmonic_phase_sequencer
// Per-sample phase engine for the additive oscillator. After reset it clears
// the sample-position RAM, then on every sample strobe walks the active
// harmonics: read position, add the harmonic's increment, write back, and
// emit the new phase (top bits) as a sine-LUT address.
//
// Optional feature macro: NYQUIST_LIMIT_EN
//   When defined, a frame stops at the first harmonic whose increment reaches
//   half the position range, so aliasing partials are never emitted.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   sample_clock         one-cycle frame-start strobe
//   freq_inc             fundamental phase increment (latched per frame)
//   harmonic_count       requested harmonics, clamped to 2^ADDR_WIDTH
//   ram_addr/din/we      RAM write port, combinational from state/counter
//   ram_dout             RAM read data, same cycle as ram_addr
//   lut_addr, lut_valid  registered new phase (top LUT_WIDTH bits) + valid
//   harmonic_index       registered index of the harmonic on lut_addr
//   busy, done, overrun  registered status (done/overrun are 1-cycle pulses)
// -----------------------------------------------------------------------------
module harmonic_phase_sequencer #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned POS_WIDTH  = 16,
   parameter int unsigned FREQ_WIDTH = 16,
   parameter int unsigned LUT_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sample_clock,
   input  logic [FREQ_WIDTH-1:0] freq_inc,
   input  logic [ADDR_WIDTH:0]   harmonic_count,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [POS_WIDTH-1:0]  ram_din,
   output logic                  ram_we,
   input  logic [POS_WIDTH-1:0]  ram_dout,
   output logic [LUT_WIDTH-1:0]  lut_addr,
   output logic                  lut_valid,
   output logic [ADDR_WIDTH-1:0] harmonic_index,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;
   localparam int unsigned ACC_W = FREQ_WIDTH + ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] MAX_H = CNT_W'(1) << ADDR_WIDTH;
`ifdef NYQUIST_LIMIT_EN
   localparam logic [ACC_W-1:0] NYQ_LIMIT = ACC_W'(1) << (POS_WIDTH - 1);
`endif

   typedef enum logic [2:0] {
      S_START,
      S_INIT,
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [FREQ_WIDTH-1:0] f_q, f_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [LUT_WIDTH-1:0]  lut_addr_q, lut_addr_d;
   logic                  lut_valid_q, lut_valid_d;
   logic [ADDR_WIDTH-1:0] hidx_q, hidx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  overrun_q, overrun_d;

   logic [POS_WIDTH-1:0]  sum_c;
   logic [CNT_W-1:0]      n_clamp_c;
   logic                  last_c;
   logic                  nyq_stop_c;

   // The counter doubles as the INIT clear address and the RUN harmonic index.
   assign ram_addr       = cnt_q;
   assign lut_addr       = lut_addr_q;
   assign lut_valid      = lut_valid_q;
   assign harmonic_index = hidx_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign overrun        = overrun_q;

   // Next-state, datapath and combinational RAM port.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      f_d         = f_q;
      acc_d       = acc_q;
      lut_addr_d  = lut_addr_q;
      lut_valid_d = 1'b0;
      hidx_d      = hidx_q;
      ram_we      = 1'b0;
      ram_din     = '0;

      sum_c     = ram_dout + acc_q[POS_WIDTH-1:0];
      n_clamp_c = (harmonic_count > MAX_H) ? MAX_H : harmonic_count;
      last_c    = ((CNT_W'(cnt_q) + CNT_W'(1)) == n_q);
`ifdef NYQUIST_LIMIT_EN
      nyq_stop_c = (acc_q >= NYQ_LIMIT);
`else
      nyq_stop_c = 1'b0;
`endif

      unique case (state_q)
         S_START: begin
            cnt_d   = '0;
            state_d = S_INIT;
         end
         S_INIT: begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == '1) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (sample_clock) begin
               f_d     = freq_inc;
               n_d     = n_clamp_c;
               acc_d   = ACC_W'(freq_inc);
               cnt_d   = '0;
               state_d = (n_clamp_c == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (nyq_stop_c) begin
               state_d = S_DONE;
            end else begin
               ram_we      = 1'b1;
               ram_din     = sum_c;
               lut_addr_d  = sum_c[POS_WIDTH-1 -: LUT_WIDTH];
               lut_valid_d = 1'b1;
               hidx_d      = cnt_q;
               cnt_d       = cnt_q + ADDR_WIDTH'(1);
               acc_d       = acc_q + ACC_W'(f_q);
               if (last_c) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_START;
         end
      endcase

      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      overrun_d = sample_clock && (state_q != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_START;
         cnt_q       <= '0;
         n_q         <= '0;
         f_q         <= '0;
         acc_q       <= '0;
         lut_addr_q  <= '0;
         lut_valid_q <= 1'b0;
         hidx_q      <= '0;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         f_q         <= f_d;
         acc_q       <= acc_d;
         lut_addr_q  <= lut_addr_d;
         lut_valid_q <= lut_valid_d;
         hidx_q      <= hidx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_harmonic_phase_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_harmonic_phase_sequencer
// Directed bench for harmonic_phase_sequencer with a behavioural
// single-port RAM (write on clock edge, combinational read). The RAM can be
// preset to a non-zero pattern so the post-reset clear is observable.
// Honours NYQUIST_LIMIT_EN for the Nyquist scenario expectations.
// -----------------------------------------------------------------------------
module tb_harmonic_phase_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_clock = 1'b0;
   logic [15:0] freq_inc = '0;
   logic [8:0]  harmonic_count = '0;
   logic [7:0]  ram_addr;
   logic [15:0] ram_din;
   logic        ram_we;
   logic [15:0] ram_dout;
   logic [10:0] lut_addr;
   logic        lut_valid;
   logic [7:0]  harmonic_index;
   logic        busy;
   logic        done;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   harmonic_phase_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .sample_clock   (sample_clock),
      .freq_inc       (freq_inc),
      .harmonic_count (harmonic_count),
      .ram_addr       (ram_addr),
      .ram_din        (ram_din),
      .ram_we         (ram_we),
      .ram_dout       (ram_dout),
      .lut_addr       (lut_addr),
      .lut_valid      (lut_valid),
      .harmonic_index (harmonic_index),
      .busy           (busy),
      .done           (done),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   // Behavioural sample-position RAM.
   logic [15:0] mem [256];
   logic        preset = 1'b0;
   always @(posedge clk) begin
      if (preset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA5A5;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_din;
      end
   end
   assign ram_dout = mem[ram_addr];

   // Frame observation record (filled by run_frame, checked by test tasks).
   logic [7:0]  wr_addr [$];
   logic [15:0] wr_data [$];
   int          wr_c    [$];
   logic [10:0] lut_a   [$];
   logic [7:0]  lut_h   [$];
   int          lut_c   [$];
   int done_c, done_n, idle_c, ovr_c, ovr_n;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe a frame at the next edge (T) and record activity; cycle c is T+c.
   task automatic run_frame(input logic [15:0] freq, input logic [8:0] hc,
                            input int strobe_at, input logic [15:0] mid_freq,
                            input logic [8:0] mid_hc);
      wr_addr.delete(); wr_data.delete(); wr_c.delete();
      lut_a.delete(); lut_h.delete(); lut_c.delete();
      done_c = -1; done_n = 0; idle_c = -1; ovr_c = -1; ovr_n = 0;
      freq_inc = freq; harmonic_count = hc; sample_clock = 1'b1;
      tick();
      sample_clock = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (ram_we) begin wr_addr.push_back(ram_addr); wr_data.push_back(ram_din); wr_c.push_back(c); end
         if (lut_valid) begin lut_a.push_back(lut_addr); lut_h.push_back(harmonic_index); lut_c.push_back(c); end
         if (done) begin done_n++; if (done_c < 0) done_c = c; end
         if (overrun) begin ovr_n++; ovr_c = c; end
         if (!busy) begin idle_c = c; break; end
         if (c == strobe_at) begin sample_clock = 1'b1; freq_inc = mid_freq; harmonic_count = mid_hc; end
         tick();
         sample_clock = 1'b0;
      end
   endtask

   task automatic reset_and_init();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (257) tick();
   endtask

   task automatic test_reset();
      logic [47:0] rv;
      reset_n = 1'b0; preset = 1'b1;
      tick(); tick();
      rv = {ram_we, ram_addr, ram_din, lut_addr, lut_valid, harmonic_index, done, overrun, busy};
      checks++; if (rv !== 48'd1) begin errors++; $display("FAIL reset_vals: got %h want %h", rv, 48'd1); end
      preset = 1'b0;
      tick();
   endtask

   // Release reset and follow START + 256 INIT writes into IDLE.
   task automatic test_init(input bit inject);
      logic [26:0] obs;
      int nz;
      reset_n = 1'b1;
      obs = {ram_we, ram_addr, ram_din, busy};
      checks++; if (obs !== 27'd1) begin errors++; $display("FAIL start_no_write: got %h want %h", obs, 27'd1); end
      tick();
      for (int i = 0; i < 256; i++) begin
         obs = {ram_we, ram_addr, ram_din, busy};
         checks++;
         if (obs !== {1'b1, 8'(i), 16'h0000, 1'b1}) begin
            errors++; $display("FAIL init_write[%0d]: got %h want %h", i, obs, {1'b1, 8'(i), 16'h0000, 1'b1});
         end
         if (inject && i == 10) sample_clock = 1'b1;
         tick();
         sample_clock = 1'b0;
         if (inject && i == 10) begin
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL init_overrun: got %b want 1", overrun); end
         end
      end
      obs = {23'd0, busy, ram_we, lut_valid, done};
      checks++; if (obs !== 27'd0) begin errors++; $display("FAIL init_idle: got %h want 0", obs); end
      nz = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 16'h0000) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL init_cleared: got %0d nonzero want 0", nz); end
   endtask

   // Two consecutive frames, the second strobed on the first accepted edge.
   task automatic test_basic_back_to_back();
      for (int f = 1; f <= 2; f++) begin
         run_frame(16'h0100, 9'd4, 0, 16'h0100, 9'd4);
         checks++; if (wr_data.size() !== 4) begin errors++; $display("FAIL basic%0d_nwr: got %0d want 4", f, wr_data.size()); end
         checks++; if (lut_a.size() !== 4) begin errors++; $display("FAIL basic%0d_nlut: got %0d want 4", f, lut_a.size()); end
         for (int i = 0; i < wr_data.size() && i < 4; i++) begin
            checks++;
            if ({wr_addr[i], wr_data[i], 8'(wr_c[i])} !== {8'(i), 16'((i + 1) * f * 256), 8'(i + 1)}) begin
               errors++; $display("FAIL basic%0d_wr[%0d]: got a=%0h d=%0h c=%0d want a=%0h d=%0h c=%0d",
                                  f, i, wr_addr[i], wr_data[i], wr_c[i], i, 16'((i + 1) * f * 256), i + 1);
            end
         end
         for (int i = 0; i < lut_a.size() && i < 4; i++) begin
            checks++;
            if ({lut_a[i], lut_h[i], 8'(lut_c[i])} !== {11'((i + 1) * f * 8), 8'(i), 8'(i + 2)}) begin
               errors++; $display("FAIL basic%0d_lut[%0d]: got l=%0d h=%0d c=%0d want l=%0d h=%0d c=%0d",
                                  f, i, lut_a[i], lut_h[i], lut_c[i], (i + 1) * f * 8, i, i + 2);
            end
         end
         checks++; if ({done_c, done_n, idle_c, ovr_n} !== {32'd5, 32'd1, 32'd6, 32'd0}) begin
            errors++; $display("FAIL basic%0d_timing: got done=%0d n=%0d idle=%0d ovr=%0d want 5 1 6 0", f, done_c, done_n, idle_c, ovr_n);
         end
      end
   endtask

   // Build 0xFF00 at address 0 (from 0x0200), then add 0x0200 and wrap.
   task automatic test_wrap();
      logic [15:0] exp_d [3];
      logic [15:0] fq [3];
      exp_d = '{16'h8080, 16'hFF00, 16'h0100};
      fq    = '{16'h7E80, 16'h7E80, 16'h0200};
      for (int k = 0; k < 3; k++) begin
         run_frame(fq[k], 9'd1, 0, fq[k], 9'd1);
         checks++;
         if (wr_data.size() !== 1 || wr_data[0] !== exp_d[k] || wr_addr[0] !== 8'h00) begin
            errors++; $display("FAIL wrap_step%0d: got n=%0d d=%h want n=1 d=%h", k, wr_data.size(), wr_data[0], exp_d[k]);
         end
      end
      checks++; if (lut_a.size() !== 1 || lut_a[0] !== 11'd8) begin errors++; $display("FAIL wrap_lut: got %0d want 8", lut_a[0]); end
      checks++; if (done_c !== 2 || idle_c !== 3) begin errors++; $display("FAIL wrap_timing: got done=%0d idle=%0d want 2 3", done_c, idle_c); end
   endtask

   task automatic test_zero_count();
      run_frame(16'h0100, 9'd0, 0, 16'h0100, 9'd0);
      checks++; if (wr_data.size() !== 0) begin errors++; $display("FAIL zero_nwr: got %0d want 0", wr_data.size()); end
      checks++; if (lut_a.size() !== 0) begin errors++; $display("FAIL zero_nlut: got %0d want 0", lut_a.size()); end
      checks++; if ({done_c, done_n, idle_c} !== {32'd1, 32'd1, 32'd2}) begin
         errors++; $display("FAIL zero_timing: got done=%0d n=%0d idle=%0d want 1 1 2", done_c, done_n, idle_c);
      end
   endtask

   task automatic test_nyquist();
      logic [15:0] exp_d [8];
      logic [10:0] exp_l [8];
      int nw, dc;
      exp_d = '{16'h3000, 16'h6000, 16'h9000, 16'hC000, 16'hF000, 16'h2000, 16'h5000, 16'h8000};
      exp_l = '{11'h180, 11'h300, 11'h480, 11'h600, 11'h780, 11'h100, 11'h280, 11'h400};
`ifdef NYQUIST_LIMIT_EN
      nw = 2; dc = 4;
`else
      nw = 8; dc = 9;
`endif
      reset_and_init();
      run_frame(16'h3000, 9'd8, 0, 16'h3000, 9'd8);
      checks++; if (wr_data.size() !== nw) begin errors++; $display("FAIL nyq_nwr: got %0d want %0d", wr_data.size(), nw); end
      checks++; if (lut_a.size() !== nw) begin errors++; $display("FAIL nyq_nlut: got %0d want %0d", lut_a.size(), nw); end
      for (int i = 0; i < wr_data.size() && i < nw; i++) begin
         checks++;
         if ({wr_addr[i], wr_data[i], lut_a[i]} !== {8'(i), exp_d[i], exp_l[i]}) begin
            errors++; $display("FAIL nyq_h%0d: got a=%0h d=%h l=%h want a=%0h d=%h l=%h",
                               i, wr_addr[i], wr_data[i], lut_a[i], i, exp_d[i], exp_l[i]);
         end
      end
      checks++; if (done_c !== dc) begin errors++; $display("FAIL nyq_done: got %0d want %0d", done_c, dc); end
   endtask

   task automatic test_clamp();
      int bad;
      reset_and_init();
      run_frame(16'h0010, 9'd300, 0, 16'h0010, 9'd300);
      checks++; if (wr_data.size() !== 256) begin errors++; $display("FAIL clamp_nwr: got %0d want 256", wr_data.size()); end
      bad = 0;
      for (int i = 0; i < wr_data.size(); i++)
         if (wr_addr[i] !== 8'(i) || wr_data[i] !== 16'((i + 1) * 16) || wr_c[i] !== i + 1) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_seq: got %0d bad writes want 0", bad); end
      checks++; if (wr_addr.size() == 0 || wr_addr[wr_addr.size() - 1] !== 8'd255) begin
         errors++; $display("FAIL clamp_last_addr: got %0d want 255", wr_addr.size() == 0 ? -1 : int'(wr_addr[wr_addr.size() - 1]));
      end
      checks++; if ({done_c, idle_c} !== {32'd257, 32'd258}) begin errors++; $display("FAIL clamp_timing: got done=%0d idle=%0d want 257 258", done_c, idle_c); end
   endtask

   // Strobe (with new freq/count) at T+2 of a 4-harmonic frame; frame must be unaffected.
   task automatic test_overrun();
      run_frame(16'h0100, 9'd4, 2, 16'h1234, 9'd7);
      checks++; if ({ovr_c, ovr_n} !== {32'd3, 32'd1}) begin errors++; $display("FAIL ovr_pulse: got c=%0d n=%0d want 3 1", ovr_c, ovr_n); end
      checks++; if (wr_data.size() !== 4) begin errors++; $display("FAIL ovr_nwr: got %0d want 4", wr_data.size()); end
      for (int i = 0; i < wr_data.size() && i < 4; i++) begin
         checks++;
         if ({wr_addr[i], wr_data[i]} !== {8'(i), 16'((i + 1) * 16'h0110)}) begin
            errors++; $display("FAIL ovr_wr[%0d]: got a=%0h d=%h want a=%0h d=%h", i, wr_addr[i], wr_data[i], i, 16'((i + 1) * 16'h0110));
         end
      end
      checks++; if ({done_c, idle_c} !== {32'd5, 32'd6}) begin errors++; $display("FAIL ovr_timing: got done=%0d idle=%0d want 5 6", done_c, idle_c); end
   endtask

   task automatic test_reset_midframe();
      logic [47:0] rv;
      freq_inc = 16'h0100; harmonic_count = 9'd4; sample_clock = 1'b1;
      tick();
      sample_clock = 1'b0;
      tick();
      checks++; if (lut_valid !== 1'b1) begin errors++; $display("FAIL midrst_running: got %b want 1", lut_valid); end
      reset_n = 1'b0;
      #1;
      rv = {ram_we, ram_addr, ram_din, lut_addr, lut_valid, harmonic_index, done, overrun, busy};
      checks++; if (rv !== 48'd1) begin errors++; $display("FAIL midrst_async: got %h want %h", rv, 48'd1); end
      tick();
      rv = {ram_we, ram_addr, ram_din, lut_addr, lut_valid, harmonic_index, done, overrun, busy};
      checks++; if (rv !== 48'd1) begin errors++; $display("FAIL midrst_held: got %h want %h", rv, 48'd1); end
      test_init(1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init(1'b1);
      test_basic_back_to_back();
      test_wrap();
      test_zero_count();
      test_nyquist();
      test_clamp();
      test_overrun();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/harmonic_phase_sequencer.md
# harmonic_phase_sequencer

Per-sample engine for the additive oscillator: on each sample strobe it walks the active harmonics, reads each stored phase position from the sample-position RAM, advances it by that harmonic's increment, writes it back and emits the new phase as a sine-LUT address. It sits directly in front of the sample-position RAM, which is single-port with write on clock edge and combinational read, and drives the sine LUT / mixer downstream. After reset it also clears the whole RAM, because the RAM has no initialisation.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: RAM address width; max harmonics = 2^ADDR_WIDTH.
- `POS_WIDTH`, 16: phase position width (RAM data width).
- `FREQ_WIDTH`, 16: fundamental increment width.
- `LUT_WIDTH`, 11: sine LUT address width (top bits of position).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_clock`  in  1  one-cycle frame-start strobe at sample rate.
- `freq_inc`  in  FREQ_WIDTH  fundamental phase increment per sample.
- `harmonic_count`  in  ADDR_WIDTH+1  requested harmonics, 0..2^ADDR_WIDTH.
- `ram_addr`  out  ADDR_WIDTH  RAM address (combinational from state/counter).
- `ram_din`  out  POS_WIDTH  RAM write data (combinational).
- `ram_we`  out  1  RAM write enable (combinational).
- `ram_dout`  in  POS_WIDTH  RAM read data, same-cycle.
- `lut_addr`  out  LUT_WIDTH  registered new phase, top LUT_WIDTH bits.
- `lut_valid`  out  1  registered; `lut_addr` and `harmonic_index` valid.
- `harmonic_index`  out  ADDR_WIDTH  registered index of harmonic on `lut_addr`.
- `busy`  out  1  high in START, INIT, RUN and DONE.
- `done`  out  1  one-cycle pulse, frame complete.
- `overrun`  out  1  one-cycle pulse, `sample_clock` arrived while busy.

## Operation
- States: START, INIT, IDLE, RUN, DONE.
- Reset state: START, counter 0, increment accumulator 0.
  - Reset values: `ram_we`=0, `ram_addr`=0, `ram_din`=0, `lut_addr`=0, `lut_valid`=0, `harmonic_index`=0, `done`=0, `overrun`=0, `busy`=1.
- START: one cycle, no RAM write, then INIT.
- INIT: `ram_we`=1, `ram_din`=0, `ram_addr`=counter. The counter runs 0..2^ADDR_WIDTH-1, then the block enters IDLE.
- IDLE: `ram_we`=0. On `sample_clock`:
  - latch `freq_inc` into F;
  - latch N = min(`harmonic_count`, 2^ADDR_WIDTH);
  - set accumulator A = F and h = 0;
  - go to RUN, or to DONE if N = 0.
- RUN, one harmonic per cycle:
  - `ram_addr`=h, `ram_we`=1;
  - `ram_din` = (`ram_dout` + A[POS_WIDTH-1:0]) mod 2^POS_WIDTH;
  - register `lut_addr` = `ram_din`[POS_WIDTH-1 -: LUT_WIDTH], `harmonic_index`=h, `lut_valid`=1;
  - then h++ and A += F.
  - A is FREQ_WIDTH+ADDR_WIDTH+1 bits wide and never wraps.
  - Go to DONE after harmonic N-1, or earlier via the Nyquist check (see Configuration).
- DONE: `done`=1 for one cycle, then IDLE.
- `sample_clock` in any state other than IDLE: ignored, `overrun` pulses the next cycle.
- `freq_inc` and `harmonic_count` changes mid-frame have no effect until the next frame.
- `reset_n` asserted mid-frame: immediate return to START. The partly updated RAM is cleared again by INIT.

## Timing
- INIT occupies 2^ADDR_WIDTH cycles, starting the cycle after START. IDLE is reached 2^ADDR_WIDTH+1 cycles after reset release.
- `sample_clock` sampled high in IDLE at edge T:
  - RUN covers cycles T+1..T+N, with the write of harmonic h at edge T+1+h;
  - `lut_valid` is high T+2..T+N+1;
  - DONE / `done` occurs at cycle T+N+1;
  - IDLE is reached at T+N+2, so the earliest accepted strobe is at edge T+N+2.
- `done` coincides with the last `lut_valid`.
- `busy` falls in the cycle after `done`.

## Configuration
- `NYQUIST_LIMIT_EN` defined:
  - before each RUN write, if A >= 2^(POS_WIDTH-1), no write occurs and the state goes straight to DONE that cycle;
  - `lut_valid` is therefore not asserted for that harmonic;
  - if harmonic 0 already exceeds the limit, the frame is RUN for one cycle, then DONE, with zero writes.
- Undefined: all N harmonics are processed; the increment folds mod 2^POS_WIDTH.

## Test plan
- Init: release reset → `ram_we`=1, `ram_din`=0 on addresses 0..255 in consecutive cycles; a `sample_clock` during INIT → `overrun` pulse, no frame started.
- Basic frame: `freq_inc`=0x0100, `harmonic_count`=4 on cleared RAM → writes 0x0100/0x0200/0x0300/0x0400 to addresses 0..3; `lut_addr`=8/16/24/32; `done` at T+5. Second frame → 0x0200/0x0400/0x0600/0x0800.
- Nyquist with macro: `freq_inc`=0x3000, `harmonic_count`=8 → only h0=0x3000 and h1=0x6000 written; `done` at T+4. Without macro: 8 writes, h2 = 0x9000.
- Boundaries:
  - `harmonic_count`=0 → no write, `done` at T+1;
  - `harmonic_count`=300 → clamped to 256 writes, addr 255 last;
  - position 0xFF00 + increment 0x0200 → 0x0100 (wrap).
- Overrun and reset: `sample_clock` at T+2 of a 4-harmonic frame → `overrun` at T+3, frame unchanged; `reset_n` low at T+2 → all outputs at reset values, INIT restarts after release.
